// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, req/gnt/rvalid bus handshake, load formatting.
// Optional bus-wait abort enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The abort counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    function automatic logic f_legal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lo[0];
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] f_be(input logic we, input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        if (!we) begin
            be = 4'b1111;
        end else begin
            case (sz)
                2'b00:   be = 4'b0001 << lo;
                2'b01:   be = 4'b0011 << lo;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] d;
        sh = rd >> {lo, 3'b000};
        case (f3)
            3'b000:  d = {{24{sh[7]}}, sh[7:0]};
            3'b100:  d = {24'h000000, sh[7:0]};
            3'b001:  d = {{16{sh[15]}}, sh[15:0]};
            3'b101:  d = {16'h0000, sh[15:0]};
            default: d = rd;
        endcase
        return d;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        start_s;
    logic        legal_s;
    logic        accept_s;
    logic        bad_start_s;
    logic        timeout_s;
    logic        abort_s;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;
    logic        resp_valid_r;
    logic [31:0] load_data_r;
    logic        misalign_err_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;

    // Request decode, next-state selection and the stall hold signal.
    always_comb begin
        start_s      = ex_valid & (mem_read | mem_write);
        legal_s      = f_legal(mem_write, funct3, mem_addr[1:0]);
        accept_s     = 1'b0;
        bad_start_s  = 1'b0;
        abort_s      = 1'b0;
        state_next_s = state_r;
        if (!rst && state_r == ST_IDLE && start_s) begin
            accept_s    = legal_s;
            bad_start_s = ~legal_s;
        end else begin
            accept_s    = 1'b0;
            bad_start_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_REQ;
                else          state_next_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_next_s = bus_we_r ? ST_DONE : ST_WAIT;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    state_next_s = ST_DONE;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
        stall = ~rst & (accept_s | (state_r == ST_REQ) | (state_r == ST_WAIT));
    end

    // State register plus all registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            bus_req_r      <= 1'b0;
            bus_we_r       <= 1'b0;
            bus_addr_r     <= 32'h0000_0000;
            bus_be_r       <= 4'b0000;
            bus_wdata_r    <= 32'h0000_0000;
            resp_valid_r   <= 1'b0;
            load_data_r    <= 32'h0000_0000;
            misalign_err_r <= 1'b0;
            funct3_r       <= 3'b000;
            addr_lo_r      <= 2'b00;
        end else begin
            state_r        <= state_next_s;
            bus_req_r      <= (state_next_s == ST_REQ);
            resp_valid_r   <= (state_next_s == ST_DONE);
            misalign_err_r <= bad_start_s;
            if (accept_s) begin
                bus_we_r    <= mem_write;
                bus_addr_r  <= {mem_addr[31:2], 2'b00};
                bus_be_r    <= f_be(mem_write, funct3[1:0], mem_addr[1:0]);
                bus_wdata_r <= f_wdata(funct3[1:0], mem_wdata);
                funct3_r    <= funct3;
                addr_lo_r   <= mem_addr[1:0];
            end
            // Stores report zero data; loads capture only in WAIT.
            if (state_r == ST_WAIT && bus_rvalid) begin
                load_data_r <= f_load(funct3_r, addr_lo_r, bus_rdata);
            end else if (state_r == ST_REQ && bus_gnt && bus_we_r) begin
                load_data_r <= 32'h0000_0000;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt_r;
    logic       bus_err_r;

    assign timeout_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) && (to_cnt_r >= TO_LAST);

    // Wait budget shared by REQ and WAIT, restarted on each accepted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r  <= 8'd0;
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= abort_s;
            if (accept_s) begin
                to_cnt_r <= 8'd0;
            end else if (state_r == ST_REQ || state_r == ST_WAIT) begin
                to_cnt_r <= to_cnt_r + 8'd1;
            end
        end
    end

    assign bus_err = bus_err_r;
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_be       = bus_be_r;
    assign bus_wdata    = bus_wdata_r;
    assign resp_valid   = resp_valid_r;
    assign load_data    = load_data_r;
    assign misalign_err = misalign_err_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference model.
module tb_lsu_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misalign_err, bus_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = 32'h0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .load_data(load_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Reference model, written from the access rules.
    function automatic logic model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz;
        sz = int'(f3) % 4;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (wr && f3 >= 3'd4) return 1'b0;
        if (sz == 1 && (addr % 2) != 0) return 1'b0;
        if (sz == 2 && (addr % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned lane;
        lane = addr % 4;
        if (!wr) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << lane);
        if (f3 == 3'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (addr % 4));
        case (f3)
            3'd0: return ((v % 256) >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
            3'd4: return v % 256;
            3'd1: return ((v % 65536) >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
            3'd5: return v % 65536;
            default: return rd;
        endcase
    endfunction

    // One full access, started at a negedge with the DUT idle; ends at a negedge, idle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             input logic rv_in_gnt);
        logic legal;
        legal = model_legal(wr, f3, addr);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        mem_addr = addr; mem_wdata = wd;
        #1;
        checks++; if (stall !== legal) begin errors++; $display("FAIL stall_on_start: got %b exp %b", stall, legal); end
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!legal) begin
            checks++; if ({misalign_err, bus_req, stall} !== 3'b100) begin errors++; $display("FAIL misalign_pulse: got err/req/stall %b exp 100", {misalign_err, bus_req, stall}); end
            @(posedge clk); @(negedge clk);
            checks++; if ({misalign_err, bus_req, resp_valid} !== 3'b000) begin errors++; $display("FAIL misalign_after: got err/req/resp %b exp 000", {misalign_err, bus_req, resp_valid}); end
            checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL load_hold_misalign: got %h exp %h", load_data, exp_ld); end
            return;
        end
        checks++; if ({bus_req, stall, bus_we, misalign_err} !== {1'b1, 1'b1, wr, 1'b0}) begin errors++; $display("FAIL req_phase: got req/stall/we/err %b exp %b", {bus_req, stall, bus_we, misalign_err}, {1'b1, 1'b1, wr, 1'b0}); end
        checks++; if (bus_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL bus_addr: got %h exp %h", bus_addr, addr & 32'hFFFF_FFFC); end
        checks++; if (bus_be !== model_be(wr, f3, addr)) begin errors++; $display("FAIL bus_be: got %b exp %b", bus_be, model_be(wr, f3, addr)); end
        if (wr) begin
            checks++; if (bus_wdata !== model_wdata(f3, wd)) begin errors++; $display("FAIL bus_wdata: got %h exp %h", bus_wdata, model_wdata(f3, wd)); end
        end
        for (int i = 0; i < gnt_dly; i++) begin
            @(posedge clk); @(negedge clk);
            checks++; if ({bus_req, stall, resp_valid} !== 3'b110) begin errors++; $display("FAIL req_hold: got req/stall/resp %b exp 110", {bus_req, stall, resp_valid}); end
        end
        bus_gnt = 1'b1; bus_rvalid = rv_in_gnt; bus_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b exp 0", bus_req); end
        if (wr) begin
            exp_ld = 32'h0;
            checks++; if ({resp_valid, stall} !== 2'b10) begin errors++; $display("FAIL store_resp: got resp/stall %b exp 10", {resp_valid, stall}); end
            checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL store_ld_zero: got %h exp %h", load_data, exp_ld); end
        end else begin
            checks++; if ({resp_valid, stall} !== 2'b01) begin errors++; $display("FAIL wait_enter: got resp/stall %b exp 01", {resp_valid, stall}); end
            for (int i = 1; i < rv_dly; i++) begin
                @(posedge clk); @(negedge clk);
                checks++; if ({resp_valid, stall, bus_req} !== 3'b010) begin errors++; $display("FAIL wait_hold: got resp/stall/req %b exp 010", {resp_valid, stall, bus_req}); end
            end
            bus_rvalid = 1'b1; bus_rdata = rdata;
            @(posedge clk); @(negedge clk);
            bus_rvalid = 1'b0;
            exp_ld = model_load(f3, addr, rdata);
            checks++; if ({resp_valid, stall} !== 2'b10) begin errors++; $display("FAIL load_resp: got resp/stall %b exp 10", {resp_valid, stall}); end
            checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL load_data: got %h exp %h", load_data, exp_ld); end
        end
        @(posedge clk); @(negedge clk);
        checks++; if ({resp_valid, bus_req, stall, bus_err} !== 4'b0000) begin errors++; $display("FAIL resp_one_cycle: got resp/req/stall/berr %b exp 0000", {resp_valid, bus_req, stall, bus_err}); end
        checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL load_hold: got %h exp %h", load_data, exp_ld); end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd2;
        mem_addr = 32'h1000_0100; mem_wdata = 32'hDEAD_BEEF;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        checks++; if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, resp_valid, load_data, misalign_err, bus_err} !== 104'h0) begin errors++; $display("FAIL reset_outputs: got nonzero, req %b addr %h be %b wdata %h ld %h", bus_req, bus_addr, bus_be, bus_wdata, load_data); end
        ex_valid = 1'b0; mem_write = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if ({bus_req, stall, resp_valid} !== 3'b000) begin errors++; $display("FAIL reset_idle: got %b exp 000", {bus_req, stall, resp_valid}); end
    endtask

    task automatic test_store_word();
        do_access(1'b0, 1'b1, 3'd2, 32'h1000_0100, 32'hDEAD_BEEF, 2, 1, 32'h0, 1'b0);
    endtask

    task automatic test_load_byte();
        do_access(1'b1, 1'b0, 3'd0, 32'h1000_0003, 32'h0, 1, 3, 32'h80FF_1234, 1'b0);
        do_access(1'b1, 1'b0, 3'd4, 32'h1000_0003, 32'h0, 1, 3, 32'h80FF_1234, 1'b1);
    endtask

    task automatic test_store_half_misalign();
        do_access(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 0, 1, 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 3'd1, 32'h0000_2001, 32'h0, 0, 1, 32'h0, 1'b0);
        do_access(1'b1, 1'b1, 3'd4, 32'h0000_2000, 32'h1234_5678, 0, 1, 32'h0, 1'b0);
        do_access(1'b1, 1'b1, 3'd0, 32'h0000_2001, 32'h0000_0077, 1, 1, 32'h0, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; mem_addr = 32'h0000_3000;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; mem_read = 1'b0; bus_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_gnt = 1'b0;
        checks++; if ({bus_req, stall} !== 2'b01) begin errors++; $display("FAIL rst_wait_entry: got req/stall %b exp 01", {bus_req, stall}); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        exp_ld = 32'h0;
        checks++; if ({bus_req, stall, resp_valid} !== 3'b000) begin errors++; $display("FAIL rst_wait_idle: got %b exp 000", {bus_req, stall, resp_valid}); end
        @(posedge clk); @(negedge clk);
        bus_rvalid = 1'b0;
        checks++; if ({resp_valid, stall} !== 2'b00) begin errors++; $display("FAIL rst_wait_rvalid: got resp/stall %b exp 00", {resp_valid, stall}); end
        @(posedge clk); @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || load_data !== exp_ld) begin errors++; $display("FAIL rst_wait_after: got resp %b ld %h exp 0 %h", resp_valid, load_data, exp_ld); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        wr, rd;
            logic [2:0]  f3;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            do_access(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                      $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd2; mem_addr = 32'h0000_4000;
        @(posedge clk); @(negedge clk);
        ex_valid = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if ({bus_req, bus_err} !== 2'b10) begin errors++; $display("FAIL timeout_wait: cycle %0d got req/err %b exp 10", i, {bus_req, bus_err}); end
            @(posedge clk); @(negedge clk);
        end
        checks++; if ({bus_err, bus_req, stall, resp_valid} !== 4'b1000) begin errors++; $display("FAIL timeout_abort: got err/req/stall/resp %b exp 1000", {bus_err, bus_req, stall, resp_valid}); end
        @(posedge clk); @(negedge clk);
        checks++; if ({bus_err, bus_req, resp_valid} !== 3'b000) begin errors++; $display("FAIL timeout_after: got %b exp 000", {bus_err, bus_req, resp_valid}); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half_misalign();
        test_reset_in_wait();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
